memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares the single RAM port between instruction fetch (i-side) and data
//  access (d-side), including LL/SC. Sits between fetch/datapath and the RAM
//  model. Sequences each transfer through a grant FSM, keeps the LL link
//  register, enforces fairness and times out hung transfers.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width
//  TIMEOUT  255  max cycles in a grant state before abort (>=2)
// PORTS
//  CLK       in   1       clock, rising edge
//  nRST      in   1       synchronous active-low reset
//  iREN      in   1       instruction read request, held until ~iwait
//  iaddr     in   ADDR_W  instruction address
//  iload     out  DATA_W  fetched word
//  iwait     out  1       1 = i-side stalled
//  dREN      in   1       data read request (LW/LL)
//  dWEN      in   1       data write request (SW/SC)
//  dLL       in   1       qualifies dREN as load-linked
//  dSC       in   1       qualifies dWEN as store-conditional
//  daddr     in   ADDR_W  data address
//  dstore    in   DATA_W  store data
//  dload     out  DATA_W  load data; SC result (1 ok / 0 fail) on SC
//  dwait     out  1       1 = d-side stalled
//  ramREN    out  1       RAM read strobe
//  ramWEN    out  1       RAM write strobe
//  ramaddr   out  ADDR_W  RAM address
//  ramstore  out  DATA_W  RAM write data
//  ramload   in   DATA_W  RAM read data
//  ramstate  in   2       FREE=0 BUSY=1 ACCESS=2 ERROR=3
//  memerr    out  1       sticky: a transfer timed out
// BEHAVIOUR
//  - States: IDLE, IGNT, DGNT, SCFAIL. Registered state; RAM-side outputs
//    and waits are combinational from state + ramstate + requester inputs.
//  - Reset (nRST low at edge): state=IDLE, link.valid=0, lastD=0, timer=0,
//    memerr=0. In IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1,
//    iload=dload=0.
//  - IDLE: d-request (dREN|dWEN) and i-request both pending -> d wins unless
//    lastD=1 (previous grant was d), then i wins. Single requester wins.
//    SC with link miss -> SCFAIL (no RAM access). Else DGNT/IGNT.
//  - IGNT: ramREN=1, ramaddr=iaddr. ramstate==ACCESS -> iwait=0,
//    iload=ramload, lastD=0, next IDLE. Else iwait=1, stay.
//  - DGNT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
//    ACCESS -> dwait=0, lastD=1, next IDLE; dload=ramload for reads,
//    dload=1 for SC, 0 for plain SW.
//  - SCFAIL: dwait=0, dload=0, lastD=1, next IDLE; exactly one cycle.
//  - Minimum latency: request in IDLE at cycle N, grant state N+1, completion
//    in the first grant-state cycle with ramstate==ACCESS.
//  - BUSY/FREE in grant: hold. ERROR in grant: hold strobes (retry).
//  - Timer: clears on grant entry, +1 per grant cycle; reaching TIMEOUT ->
//    assert waiting side's wait=0 with load=0 for that cycle, set memerr,
//    next IDLE. memerr clears only on reset.
//  - Link register {valid, addr}: LL completion sets valid, addr=daddr.
//    SC (success or fail) clears valid. Any completed write (SW or SC) to
//    addr==link.addr clears valid. LL and write to same addr never coincide.
//  - dREN and dWEN both high: treated as write; requesters must hold inputs
//    stable until their wait drops; deassert mid-grant is illegal.
//  - Reset mid-grant: next edge forces IDLE; in-flight transfer is dropped.
// TESTING
//  1 Reset: nRST=0 two cycles, release -> IDLE, all strobes 0, memerr=0.
//  2 Contention: iREN, dREN both held, ramstate=ACCESS after 2 BUSY -> order
//    d,i,d,i; each dwait/iwait low exactly one cycle, ramaddr switches.
//  3 LL 0x100 -> SC 0x100 dstore=0xDEAD -> ramWEN=1, dload=1; second SC
//    0x100 -> SCFAIL, no ramWEN, dload=0, latency 2 cycles.
//  4 LL 0x200, SW 0x200, SC 0x200 -> SC fails; LL 0x200, SW 0x204 -> SC ok.
//  5 ramstate stuck BUSY, TIMEOUT=8 -> dwait=0 after 8 grant cycles,
//    memerr=1 and stays 1 until nRST=0.
//  6 nRST=0 during DGNT w/ ramstate=ERROR -> next cycle IDLE, link cleared.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between the instruction-fetch side and
// the data side (including LL/SC). A four-state grant FSM sequences each
// transfer, a link register tracks the outstanding load-linked address, a
// last-grant flag alternates priority under contention, and a grant timer
// aborts transfers the RAM never completes.
module memory_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              nRST,
   // instruction side
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [DATA_W-1:0] iload,
   output logic              iwait,
   // data side
   input  logic              dREN,
   input  logic              dWEN,
   input  logic              dLL,
   input  logic              dSC,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic [DATA_W-1:0] dload,
   output logic              dwait,
   // RAM side
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   // status
   output logic              memerr
);

   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGNT   = 2'd1,
      DGNT   = 2'd2,
      SCFAIL = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              link_valid_q, link_valid_d;
   logic [ADDR_W-1:0] link_addr_q, link_addr_d;
   logic              last_d_q, last_d_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              memerr_q, memerr_d;

   logic d_req;
   logic sc_req;
   logic link_hit;
   logic ram_done;
   logic timed_out;

   assign d_req     = dREN | dWEN;
   assign sc_req    = dWEN & dSC;
   assign link_hit  = link_valid_q && (link_addr_q == daddr);
   assign ram_done  = (ramstate == RAM_ACCESS);
   assign timed_out = (timer_q == TW'(TIMEOUT - 1));
   assign memerr    = memerr_q;

   // Next-state, link/fairness/timer updates and all requester/RAM outputs.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_d      = state_q;
      link_valid_d = link_valid_q;
      link_addr_d  = link_addr_q;
      last_d_d     = last_d_q;
      timer_d      = '0;
      memerr_d     = memerr_q;
      ramREN       = 1'b0;
      ramWEN       = 1'b0;
      ramaddr      = '0;
      ramstore     = '0;
      iwait        = 1'b1;
      dwait        = 1'b1;
      iload        = '0;
      dload        = '0;

      case (state_q)
         IDLE: begin
            // d-side wins ties unless it also won the previous grant
            if (d_req && (!iREN || !last_d_q)) begin
               if (sc_req && !link_hit) state_d = SCFAIL;
               else                     state_d = DGNT;
            end else if (iREN) begin
               state_d = IGNT;
            end
         end

         IGNT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            timer_d = timer_q + TW'(1);
            if (ram_done) begin
               iwait    = 1'b0;
               iload    = ramload;
               last_d_d = 1'b0;
               state_d  = IDLE;
            end else if (timed_out) begin
               iwait    = 1'b0;
               memerr_d = 1'b1;
               last_d_d = 1'b0;
               state_d  = IDLE;
            end
         end

         DGNT: begin
            // a simultaneous read+write request is served as a write
            ramREN   = dREN & ~dWEN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            timer_d  = timer_q + TW'(1);
            if (ram_done) begin
               dwait    = 1'b0;
               last_d_d = 1'b1;
               state_d  = IDLE;
               if (dWEN) begin
                  dload = dSC ? DATA_W'(1) : '0;
                  if (dSC || (link_addr_q == daddr)) link_valid_d = 1'b0;
               end else begin
                  dload = ramload;
                  if (dLL) begin
                     link_valid_d = 1'b1;
                     link_addr_d  = daddr;
                  end
               end
            end else if (timed_out) begin
               dwait    = 1'b0;
               memerr_d = 1'b1;
               last_d_d = 1'b1;
               state_d  = IDLE;
            end
         end

         SCFAIL: begin
            // link miss: report failure without touching the RAM
            dwait        = 1'b0;
            last_d_d     = 1'b1;
            link_valid_d = 1'b0;
            state_d      = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // State, link, fairness, timer and sticky error registers.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (!nRST) begin
         state_q      <= IDLE;
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
         last_d_q     <= 1'b0;
         timer_q      <= '0;
         memerr_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         link_valid_q <= link_valid_d;
         link_addr_q  <= link_addr_d;
         last_d_q     <= last_d_d;
         timer_q      <= timer_d;
         memerr_q     <= memerr_d;
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed bench for memory_arbiter covering reset,
// contention fairness, LL/SC link behaviour, timeout and reset mid-grant.
module tb_memory_arbiter;

   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;
   logic        dREN, dWEN, dLL, dSC;
   logic [31:0] daddr, dstore, dload;
   logic        dwait;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;
   logic        memerr;

   int tests_run = 0;
   int failed    = 0;

   memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .dLL(dLL), .dSC(dSC),
      .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .memerr(memerr)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=no finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Called in an IDLE cycle with a request already presented: runs one grant
   // with busy_n BUSY cycles then ACCESS, and returns in the following IDLE cycle.
   task automatic serve(input string tag, input logic is_d, input logic [31:0] addr,
                        input int busy_n, input logic [31:0] rload,
                        input logic [31:0] exp_load, input logic exp_ren,
                        input logic exp_wen, input logic [31:0] exp_store);
      tick();
      for (int k = 0; k < busy_n; k++) begin
         ramstate = BUSY;
         #1;
         check({tag, "_busy_addr"}, ramaddr, addr);
         check({tag, "_busy_wait"}, {31'd0, is_d ? dwait : iwait}, 32'd1);
         tick();
      end
      ramstate = ACCESS;
      ramload  = rload;
      #1;
      check({tag, "_addr"}, ramaddr, addr);
      check({tag, "_ren"}, {31'd0, ramREN}, {31'd0, exp_ren});
      check({tag, "_wen"}, {31'd0, ramWEN}, {31'd0, exp_wen});
      if (exp_wen) check({tag, "_store"}, ramstore, exp_store);
      check({tag, "_wait"}, {31'd0, is_d ? dwait : iwait}, 32'd0);
      check({tag, "_other_wait"}, {31'd0, is_d ? iwait : dwait}, 32'd1);
      check({tag, "_load"}, is_d ? dload : iload, exp_load);
      tick();
      ramstate = FREE;
      ramload  = 32'h0;
      #1;
      check({tag, "_wait_after"}, {31'd0, is_d ? dwait : iwait}, 32'd1);
   endtask

   initial begin
      nRST = 1'b0; iREN = 1'b0; iaddr = '0;
      dREN = 1'b0; dWEN = 1'b0; dLL = 1'b0; dSC = 1'b0;
      daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

      // 1: reset for two cycles
      tick(); tick();
      check("rst_ramREN", {31'd0, ramREN}, 32'd0);
      check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
      check("rst_ramaddr", ramaddr, 32'd0);
      check("rst_iwait", {31'd0, iwait}, 32'd1);
      check("rst_dwait", {31'd0, dwait}, 32'd1);
      check("rst_memerr", {31'd0, memerr}, 32'd0);
      check("rst_dload", dload, 32'd0);
      nRST = 1'b1;
      tick();

      // 2: contention, both held, order d,i,d,i
      iREN = 1'b1; iaddr = 32'h40;
      dREN = 1'b1; daddr = 32'h80;
      #1;
      check("cont_idle_iwait", {31'd0, iwait}, 32'd1);
      check("cont_idle_dwait", {31'd0, dwait}, 32'd1);
      serve("cont_d1", 1'b1, 32'h80, 2, 32'h1111, 32'h1111, 1'b1, 1'b0, 32'h0);
      serve("cont_i1", 1'b0, 32'h40, 2, 32'h2222, 32'h2222, 1'b1, 1'b0, 32'h0);
      serve("cont_d2", 1'b1, 32'h80, 2, 32'h3333, 32'h3333, 1'b1, 1'b0, 32'h0);
      serve("cont_i2", 1'b0, 32'h40, 2, 32'h4444, 32'h4444, 1'b1, 1'b0, 32'h0);
      iREN = 1'b0; dREN = 1'b0;

      // 3: LL 0x100 then SC succeeds, second SC fails via SCFAIL
      dREN = 1'b1; dLL = 1'b1; daddr = 32'h100;
      serve("ll100", 1'b1, 32'h100, 0, 32'h55, 32'h55, 1'b1, 1'b0, 32'h0);
      dREN = 1'b0; dLL = 1'b0; dWEN = 1'b1; dSC = 1'b1; dstore = 32'hDEAD;
      serve("sc100_ok", 1'b1, 32'h100, 1, 32'h0, 32'h1, 1'b0, 1'b1, 32'hDEAD);
      tick();
      check("sc100_fail_dwait", {31'd0, dwait}, 32'd0);
      check("sc100_fail_dload", dload, 32'd0);
      check("sc100_fail_wen", {31'd0, ramWEN}, 32'd0);
      tick();
      check("sc100_fail_done", {31'd0, dwait}, 32'd1);

      // 4a: LL 0x200, SW 0x200 breaks link, SC 0x200 fails
      dWEN = 1'b0; dSC = 1'b0; dREN = 1'b1; dLL = 1'b1; daddr = 32'h200;
      serve("ll200a", 1'b1, 32'h200, 0, 32'h77, 32'h77, 1'b1, 1'b0, 32'h0);
      dREN = 1'b0; dLL = 1'b0; dWEN = 1'b1; dstore = 32'h9;
      serve("sw200", 1'b1, 32'h200, 0, 32'hABCD, 32'h0, 1'b0, 1'b1, 32'h9);
      dSC = 1'b1;
      tick();
      check("sc200_fail_dwait", {31'd0, dwait}, 32'd0);
      check("sc200_fail_wen", {31'd0, ramWEN}, 32'd0);
      check("sc200_fail_dload", dload, 32'd0);
      tick();

      // 4b: LL 0x200, SW 0x204 leaves link, SC 0x200 succeeds
      dWEN = 1'b0; dSC = 1'b0; dREN = 1'b1; dLL = 1'b1; daddr = 32'h200;
      serve("ll200b", 1'b1, 32'h200, 0, 32'h78, 32'h78, 1'b1, 1'b0, 32'h0);
      dREN = 1'b0; dLL = 1'b0; dWEN = 1'b1; daddr = 32'h204; dstore = 32'hA;
      serve("sw204", 1'b1, 32'h204, 0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA);
      dSC = 1'b1; daddr = 32'h200; dstore = 32'hB;
      serve("sc200_ok", 1'b1, 32'h200, 0, 32'h0, 32'h1, 1'b0, 1'b1, 32'hB);
      dWEN = 1'b0; dSC = 1'b0;

      // 5: RAM stuck BUSY, timeout after 8 grant cycles
      dREN = 1'b1; daddr = 32'h300; ramstate = BUSY; ramload = 32'hFFFF;
      tick();
      for (int k = 1; k < 8; k++) begin
         check("to_wait_held", {31'd0, dwait}, 32'd1);
         tick();
      end
      check("to_dwait", {31'd0, dwait}, 32'd0);
      check("to_dload", dload, 32'd0);
      tick();
      check("to_back_idle", {31'd0, dwait}, 32'd1);
      check("to_memerr", {31'd0, memerr}, 32'd1);
      dREN = 1'b0; ramstate = FREE;
      tick(); tick(); tick();
      check("to_memerr_sticky", {31'd0, memerr}, 32'd1);

      // 6: reset during DGNT with ERROR, link cleared
      dREN = 1'b1; dLL = 1'b1; daddr = 32'h400;
      serve("ll400", 1'b1, 32'h400, 0, 32'h5, 32'h5, 1'b1, 1'b0, 32'h0);
      dLL = 1'b0; daddr = 32'h500; ramstate = ERROR;
      tick();
      check("err_ren_held", {31'd0, ramREN}, 32'd1);
      check("err_dwait", {31'd0, dwait}, 32'd1);
      nRST = 1'b0;
      tick();
      check("rst6_ramREN", {31'd0, ramREN}, 32'd0);
      check("rst6_dwait", {31'd0, dwait}, 32'd1);
      check("rst6_memerr", {31'd0, memerr}, 32'd0);
      nRST = 1'b1; dREN = 1'b0; ramstate = FREE;
      dWEN = 1'b1; dSC = 1'b1; daddr = 32'h400; dstore = 32'h1;
      tick();
      check("rst6_sc_fail_dwait", {31'd0, dwait}, 32'd0);
      check("rst6_sc_fail_wen", {31'd0, ramWEN}, 32'd0);
      check("rst6_sc_fail_dload", dload, 32'd0);
      dWEN = 1'b0; dSC = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
